dff_pipe: RTL

Parametrised, elastic D-flip-flop pipeline: a chain of `DEPTH` registers of `WIDTH` bits with per-stage valid bits and a valid/ready handshake at both ends. It generalises the single D flip-flop with synchronous active-low reset into a stallable delay line with flush and occupancy reporting. It is used wherever a data path needs a fixed register delay that tolerates downstream backpressure without losing or duplicating beats.

---
 rtl/dff_pipe.sv | 97 +++++++++
 1 files changed

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready at both ends, flush and occupancy count.
// Define DFF_PIPE_QN_EN to add the out_data_n port (complement of out_data).
module dff_pipe #(
  parameter int              WIDTH     = 8,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
`ifdef DFF_PIPE_QN_EN
  output logic [WIDTH-1:0]           out_data_n,
`endif
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int               OCC_W   = $clog2(DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [DEPTH-1:0] prev_v;
  logic [WIDTH-1:0] prev_d [DEPTH];
  logic [OCC_W-1:0] occ;
  logic             in_fire;
  logic             out_fire;
  logic             all_full;

  // A stage can advance if downstream drains, or if any stage from here to the end is a bubble.
  always_comb begin
    rdy      = '0;
    all_full = 1'b1;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      all_full = all_full & v[k];
      rdy[k]   = out_ready | ~all_full;
    end
  end

  always_comb begin
    prev_v    = '0;
    prev_v[0] = in_valid;
    for (int k = 0; k < DEPTH; k++) begin
      prev_d[k] = in_data;
    end
    for (int k = 1; k < DEPTH; k++) begin
      prev_v[k] = v[k-1];
      prev_d[k] = d[k-1];
    end
  end

  assign in_ready  = rdy[0] & ~flush & reset_n;
  assign out_valid = v[DEPTH-1] & ~flush & reset_n;
  assign out_data  = d[DEPTH-1];
  assign occupancy = occ;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef DFF_PIPE_QN_EN
  assign out_data_n = ~out_data;
`endif

  // Data registers only load real beats, so a bubble moving through never overwrites held data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v   <= '0;
      occ <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        d[k] <= RESET_VAL;
      end
    end else if (flush) begin
      v   <= '0;
      occ <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v[k] <= prev_v[k];
          if (prev_v[k]) begin
            d[k] <= prev_d[k];
          end
        end
      end
      if (in_fire && !out_fire) begin
        occ <= occ + OCC_ONE;
      end else if (out_fire && !in_fire) begin
        occ <= occ - OCC_ONE;
      end
    end
  end

endmodule
